product_bcd_conv: RTL and testbench

- Downstream stage of the 4x4 unsigned multiplier. Takes the registered 8-bit product and converts it to packed BCD digits using sequential double-dabble: one shift per clock.
- Output feeds the display/segment driver stage.
- Uses a valid/ready handshake on both sides, so the multiplier may present a new product every cycle while this block paces itself.

---
 rtl/product_bcd_pkg.sv | 14 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/product_bcd_conv.sv | 140 ++++++++++++++
 tb/tb_product_bcd_conv.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/product_bcd_pkg.sv
// Shared types and constants for the product-to-BCD converter.
package product_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
// Purely combinational, no handshake.
module bcd_digit_adj
    import product_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_i,
    output logic [BCD_DIGIT_W-1:0] d_o
);

    assign d_o = (d_i >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ? d_i + BCD_DIGIT_W'(BCD_ADJ_ADD) : d_i;

endmodule

// File: rtl/product_bcd_conv.sv
// Sequential double-dabble binary->BCD, one shift per clock; result valid BITS cycles after accept.
// Single job in flight, in_ready only in IDLE; PRODUCT_BCD_BLANK_EN adds a leading-zero blank mask.
module product_bcd_conv
    import product_bcd_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BITS-1:0]               bin_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
    output logic                          ovf_o,
    output logic [DIGITS-1:0]             blank_o
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SCR_W = BCD_W + BITS;
    localparam int CNT_W = $clog2(BITS + 1);

    state_t             state_q, state_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_scr_q, ovf_scr_d;
    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               res_load;

    logic [SCR_W-1:0]   scr_adj;
    logic [SCR_W-1:0]   scr_shift;
    logic               shift_out;

    // Only the BCD field is corrected; the binary tail passes straight through.
    assign scr_adj[BITS-1:0] = scr_q[BITS-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (scr_q  [BITS + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .d_o (scr_adj[BITS + g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign scr_shift = {scr_adj[SCR_W-2:0], 1'b0};
    assign shift_out = scr_adj[SCR_W-1];

    always_comb begin
        state_d   = state_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        ovf_scr_d = ovf_scr_q;
        res_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    scr_d     = {{BCD_W{1'b0}}, bin_i};
                    cnt_d     = CNT_W'(BITS);
                    ovf_scr_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scr_d     = scr_shift;
                cnt_d     = cnt_q - CNT_W'(1);
                ovf_scr_d = ovf_scr_q | shift_out;
                if (cnt_q == CNT_W'(1)) begin
                    res_load = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            scr_q     <= '0;
            cnt_q     <= '0;
            ovf_scr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            ovf_scr_q <= ovf_scr_d;
        end
    end

    // Result registers capture the post-shift value on the final shift edge only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= '0;
            ovf_q <= 1'b0;
        end else if (res_load) begin
            bcd_q <= scr_shift[SCR_W-1 -: BCD_W];
            ovf_q <= ovf_scr_q | shift_out;
        end
    end

`ifdef PRODUCT_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_d;
    logic [DIGITS-1:0] blank_q;

    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        blank_d  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero && (scr_shift[BITS + i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_d[i] = all_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else if (res_load) begin
            blank_q <= blank_d;
        end
    end

    assign blank_o = blank_q;
`else
    assign blank_o = '0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd_o     = bcd_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_product_bcd_conv.sv
// Scoreboard bench for product_bcd_conv: 3-digit and 2-digit instances share one input stream.
module tb_product_bcd_conv;

    localparam int BITS = 8;

    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
        logic [2:0]  blank;
    } exp3_t;

    typedef struct packed {
        logic [7:0] bcd;
        logic       ovf;
        logic [1:0] blank;
    } exp2_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [7:0]  bin_i;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [11:0] bcd_o;
    logic [7:0]  bcd2_o;
    logic        ovf_o, ovf2_o;
    logic [2:0]  blank_o;
    logic [1:0]  blank2_o;

    exp3_t q3[$];
    exp2_t q2[$];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    product_bcd_conv #(.BITS(BITS), .DIGITS(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_i     (bin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_o     (bcd_o),
        .ovf_o     (ovf_o),
        .blank_o   (blank_o)
    );

    product_bcd_conv #(.BITS(BITS), .DIGITS(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .bin_i     (bin_i),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .bcd_o     (bcd2_o),
        .ovf_o     (ovf2_o),
        .blank_o   (blank2_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every cycle a result is presented it must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q3.size() == 0) begin
                chk("d3_unexpected_result", q3.size(), 1);
            end else begin
                chk("d3_bcd",   bcd_o,   q3[0].bcd);
                chk("d3_ovf",   ovf_o,   q3[0].ovf);
                chk("d3_blank", blank_o, q3[0].blank);
                if (out_ready) void'(q3.pop_front());
            end
        end
        if (!rst && out_valid2) begin
            if (q2.size() == 0) begin
                chk("d2_unexpected_result", q2.size(), 1);
            end else begin
                chk("d2_bcd",   bcd2_o,   q2[0].bcd);
                chk("d2_ovf",   ovf2_o,   q2[0].ovf);
                chk("d2_blank", blank2_o, q2[0].blank);
                if (out_ready) void'(q2.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] v,
                        input logic [11:0] e3, input logic o3, input logic [2:0] b3,
                        input logic [7:0]  e2, input logic o2, input logic [1:0] b2,
                        input bit drop);
        exp3_t x3;
        exp2_t x2;
        int    c;
        int    w;
        if (!in_valid) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            bin_i    = v;
            @(negedge clk);
        end else begin
            bin_i = v;
        end
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", int'(in_ready), 1);
        @(posedge clk);
        x3.bcd = e3; x3.ovf = o3;
        x2.bcd = e2; x2.ovf = o2;
`ifdef PRODUCT_BCD_BLANK_EN
        x3.blank = b3; x2.blank = b2;
`else
        x3.blank = 3'b000; x2.blank = 2'b00;
`endif
        q3.push_back(x3);
        q2.push_back(x2);
        #1;
        if (drop) in_valid = 1'b0;
        c = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            c++;
        end
        chk("latency", c, BITS);
        chk("done_in_ready", int'(in_ready), 0);
        if (out_ready) begin
            @(negedge clk);
            chk("ready_return", int'(in_ready), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        bin_i     = 8'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_bcd",       bcd_o,           0);
        chk("rst_ovf",       int'(ovf_o),     0);
        chk("rst_blank",     blank_o,         0);
        @(posedge clk); #1;
        rst = 1'b0;

        //            v    3-digit            2-digit
        send(8'd225, 12'h225, 1'b0, 3'b000, 8'h25, 1'b1, 2'b00, 1'b1);
        send(8'd0,   12'h000, 1'b0, 3'b110, 8'h00, 1'b0, 2'b10, 1'b0);
        send(8'd99,  12'h099, 1'b0, 3'b100, 8'h99, 1'b0, 2'b00, 1'b1);

        // Consumer stalls in DONE; a new request meanwhile must be refused.
        out_ready = 1'b0;
        send(8'd144, 12'h144, 1'b0, 3'b000, 8'h44, 1'b1, 2'b00, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b1;
        bin_i    = 8'd7;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'd7,   12'h007, 1'b0, 3'b110, 8'h07, 1'b0, 2'b10, 1'b1);

        // Abort a conversion of 200 with an asynchronous reset mid-shift.
        @(posedge clk); #1;
        in_valid = 1'b1;
        bin_i    = 8'd200;
        @(negedge clk);
        chk("abort_accept_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_bcd",       bcd_o,            0);
        chk("abort_ovf",       int'(ovf_o),      0);
        chk("abort_blank",     blank_o,          0);
        chk("abort_out_valid", int'(out_valid),  0);
        chk("abort_in_ready",  int'(in_ready),   1);
        chk("abort_bcd2",      bcd2_o,           0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_in_ready", int'(in_ready), 1);

        send(8'd15,  12'h015, 1'b0, 3'b100, 8'h15, 1'b0, 2'b00, 1'b1);
        send(8'd40,  12'h040, 1'b0, 3'b100, 8'h40, 1'b0, 2'b00, 1'b1);

        repeat (5) @(negedge clk);
        chk("q3_drained", q3.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
